// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's producer, scoreboard and register-file signals.
// slave is the arbiter's view; master is everything around it.
interface wb_arbiter_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;

    logic        lng_valid;
    logic        lng_ready;
    logic [4:0]  lng_rd;
    logic [31:0] lng_data;

    logic        iss_valid;
    logic [4:0]  iss_rd;

    logic [4:0]  q_rs1;
    logic [4:0]  q_rs2;
    logic        busy1;
    logic        busy2;
    logic        stall_req;

    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lng_valid, lng_rd, lng_data,
        input  iss_valid, iss_rd,
        input  q_rs1, q_rs2,
        output lng_ready, busy1, busy2, stall_req,
        output rf_we, rf_wa, rf_wd
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lng_valid, lng_rd, lng_data,
        output iss_valid, iss_rd,
        output q_rs1, q_rs2,
        input  lng_ready, busy1, busy2, stall_req,
        input  rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and queued long-latency results onto the register file
// write port and keeps the busy scoreboard for outstanding long-latency destinations.
module wb_arbiter #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned STARVE = 3
) (
    input logic         clk,
    input logic         rstn,
    wb_arbiter_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SW = $clog2(STARVE + 2);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;
    typedef logic [SW-1:0] stv_t;

    logic [4:0]  mem_rd   [DEPTH];
    logic [31:0] mem_data [DEPTH];

    ptr_t        wptr_q, wptr_d, rptr_q, rptr_d;
    cnt_t        count_q, count_d;
    stv_t        starve_q, starve_d;
    logic        stall_q, stall_d;
    logic [31:0] busy_q, busy_d;
    logic        rf_we_q, rf_lng_q;
    logic [4:0]  rf_wa_q;
    logic [31:0] rf_wd_q;

    logic        empty, full, push, pop, sel_valid;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;

    assign empty     = (count_q == '0);
    assign full      = (count_q == cnt_t'(DEPTH));
    assign push      = bus.lng_valid && !full;
    assign pop       = !bus.alu_valid && !empty;
    assign sel_valid = bus.alu_valid || !empty;
    assign sel_rd    = bus.alu_valid ? bus.alu_rd   : mem_rd[rptr_q];
    assign sel_data  = bus.alu_valid ? bus.alu_data : mem_data[rptr_q];

    always_comb begin
        wptr_d  = push ? wptr_q + ptr_t'(1) : wptr_q;
        rptr_d  = pop  ? rptr_q + ptr_t'(1) : rptr_q;
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
        endcase

        // Head waiting behind the ALU accumulates; saturates so stall_req stays held.
        starve_d = starve_q;
        if (empty || pop) begin
            starve_d = '0;
        end else if (starve_q < stv_t'(STARVE)) begin
            starve_d = starve_q + stv_t'(1);
        end
        stall_d = (starve_d >= stv_t'(STARVE));

        // Clear first so a same-edge reissue of the address keeps it busy.
        busy_d = busy_q;
        if (rf_we_q && rf_lng_q) begin
            busy_d[rf_wa_q] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
            busy_d[bus.iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wptr_q]   <= bus.lng_rd;
            mem_data[wptr_q] <= bus.lng_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            busy_q   <= '0;
            rf_we_q  <= 1'b0;
            rf_lng_q <= 1'b0;
            rf_wa_q  <= '0;
            rf_wd_q  <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            busy_q   <= busy_d;
            rf_we_q  <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rf_lng_q <= !bus.alu_valid;
                rf_wa_q  <= sel_rd;
                rf_wd_q  <= sel_data;
            end
        end
    end

    assign bus.lng_ready = !full;
    assign bus.busy1     = busy_q[bus.q_rs1] && (bus.q_rs1 != 5'd0);
    assign bus.busy2     = busy_q[bus.q_rs2] && (bus.q_rs2 != 5'd0);
    assign bus.stall_req = stall_q;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_wa     = rf_wa_q;
    assign bus.rf_wd     = rf_wd_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts register-file
// writes, which a separate monitor checks, plus per-cycle ready/busy/stall checks.
module tb_wb_arbiter;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned STARVE = 3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    logic clk;
    logic rstn;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int         n_tests  = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         n_writes = 0;
    bit         in_reset = 1'b1;

    ent_t       mq[$];
    exp_t       exp_q[$];
    bit         mbusy[32];
    int         lost;
    bit         clr_v;
    logic [4:0] clr_a;
    bit         stall_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%h, expected 0x%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                         input bit iv, input logic [4:0] ird,
                         input logic [4:0] q1, input logic [4:0] q2);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = ad;
        bus.lng_valid = lv;
        bus.lng_rd    = lrd;
        bus.lng_data  = ld;
        bus.iss_valid = iv;
        bus.iss_rd    = ird;
        bus.q_rs1     = q1;
        bus.q_rs2     = q2;
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        foreach (mbusy[i]) mbusy[i] = 1'b0;
        lost       = 0;
        clr_v      = 1'b0;
        clr_a      = '0;
        stall_prev = 1'b0;
    endtask

    // One clock cycle: drive, check visible state against the model, then advance the model.
    task automatic step(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                        input bit lv, input logic [4:0] lrd, input logic [31:0] ld,
                        input bit iv, input logic [4:0] ird,
                        input logic [4:0] q1, input logic [4:0] q2);
        ent_t       h;
        exp_t       x;
        bit         mempty;
        bit         mready;
        bit         popped;
        bit         nclr_v;
        logic [4:0] nclr_a;
        @(negedge clk);
        drive(av, ard, ad, lv, lrd, ld, iv, ird, q1, q2);
        #1;
        mempty = (mq.size() == 0);
        mready = (mq.size() < int'(DEPTH));
        stall_prev = (lost >= int'(STARVE));
        chk("lng_ready", 32'(bus.lng_ready), 32'(mready));
        chk("busy1", 32'(bus.busy1), 32'(mbusy[q1]));
        chk("busy2", 32'(bus.busy2), 32'(mbusy[q2]));
        chk("stall_req", 32'(bus.stall_req), 32'(stall_prev));

        popped = 1'b0;
        nclr_v = 1'b0;
        nclr_a = '0;
        if (av) begin
            if (ard != 5'd0) begin
                x.cyc = cyc + 1; x.wa = ard; x.wd = ad;
                exp_q.push_back(x);
            end
        end else if (!mempty) begin
            h = mq.pop_front();
            popped = 1'b1;
            if (h.rd != 5'd0) begin
                x.cyc = cyc + 1; x.wa = h.rd; x.wd = h.data;
                exp_q.push_back(x);
                nclr_v = 1'b1;
                nclr_a = h.rd;
            end
        end
        lost = (mempty || popped) ? 0 : lost + 1;
        if (lv && mready) begin
            h.rd = lrd; h.data = ld;
            mq.push_back(h);
        end
        if (clr_v) mbusy[clr_a] = 1'b0;
        if (iv && (ird != 5'd0)) mbusy[ird] = 1'b1;
        clr_v = nclr_v;
        clr_a = nclr_a;
    endtask

    task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, q1, q2);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_reset = 1'b1;
        rstn     = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd7, 5'd14);
        #1;
        chk("rst_rf_we", 32'(bus.rf_we), 32'd0);
        chk("rst_rf_wa", 32'(bus.rf_wa), 32'd0);
        chk("rst_rf_wd", bus.rf_wd, 32'd0);
        chk("rst_lng_ready", 32'(bus.lng_ready), 32'd1);
        chk("rst_stall_req", 32'(bus.stall_req), 32'd0);
        chk("rst_busy1", 32'(bus.busy1), 32'd0);
        chk("rst_busy2", 32'(bus.busy2), 32'd0);
        model_clear();
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        in_reset = 1'b0;
    endtask

    // Monitor: every cycle the write port must match the oldest prediction due now, or be idle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!in_reset) begin
                if (bus.rf_we === 1'b1) n_writes++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("rf_we", 32'(bus.rf_we), 32'd1);
                    chk("rf_wa", 32'(bus.rf_wa), 32'(e.wa));
                    chk("rf_wd", bus.rf_wd, e.wd);
                end else begin
                    chk("rf_we_idle", 32'(bus.rf_we), 32'd0);
                end
            end
        end
    end

    initial begin
        bit         av, lv, iv;
        logic [4:0] ard, lrd, ird, q1, q2;
        int         wr0;
        int         pa;

        rstn = 1'b0;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        model_clear();
        do_reset();

        // ALU path, including the x0 destination
        step(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 5'd0, 32'hCAFE_F00D, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd5);
        idle(5'd0, 5'd0);

        // Issue rd=7, later return it via the long path
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd0, 5'd7, 5'd0);
        repeat (4) idle(5'd7, 5'd0);

        // ALU contention: fill the FIFO, starve the head, then bubble and drain
        step(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd11, 32'h0000_00D1, 1'b0, 5'd0, 5'd11, 5'd12);
        step(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd12, 32'h0000_00D2, 1'b0, 5'd0, 5'd11, 5'd12);
        step(1'b1, 5'd6, 32'h0000_0066, 1'b1, 5'd13, 32'h0000_00D3, 1'b0, 5'd0, 5'd11, 5'd12);
        step(1'b1, 5'd8, 32'h0000_0088, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd12);
        step(1'b1, 5'd10, 32'h0000_00AA, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd11, 5'd12);
        repeat (4) idle(5'd11, 5'd12);

        // Long writeback of rd=9 clears on the same edge a new issue of rd=9 sets
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0909_0909, 1'b0, 5'd0, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        idle(5'd9, 5'd0);
        idle(5'd9, 5'd0);

        // Back-to-back long pushes wrap the pointers several times
        wr0 = n_writes;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i), 1'b0, 5'd0,
                 5'(i + 1), 5'd0);
        end
        repeat (3) idle(5'd0, 5'd0);
        chk("wrap_writes", 32'(n_writes - wr0), 32'd10);

        // Reset with two entries queued and a busy destination outstanding
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 5'd7, 5'd0);
        step(1'b1, 5'd2, 32'h0000_0002, 1'b1, 5'd14, 32'h0000_0E14, 1'b0, 5'd0, 5'd7, 5'd14);
        step(1'b1, 5'd3, 32'h0000_0003, 1'b1, 5'd15, 32'h0000_0E15, 1'b0, 5'd0, 5'd7, 5'd15);
        do_reset();
        idle(5'd7, 5'd14);
        idle(5'd7, 5'd15);

        // Randomised traffic; second half is ALU-heavy to exercise full and starvation
        for (int i = 0; i < 400; i++) begin
            pa  = (i < 200) ? 50 : 85;
            av  = !stall_prev && ($urandom_range(99) < 32'(pa));
            lv  = ($urandom_range(99) < 50);
            iv  = ($urandom_range(99) < 30);
            ard = 5'($urandom_range(31));
            lrd = 5'($urandom_range(31));
            ird = 5'($urandom_range(31));
            q1  = ($urandom_range(1) == 0) ? lrd : 5'($urandom_range(31));
            q2  = ($urandom_range(1) == 0) ? ird : 5'($urandom_range(31));
            step(av, ard, $urandom, lv, lrd, $urandom, iv, ird, q1, q2);
        end

        repeat (DEPTH + 4) idle(5'd0, 5'd0);
        chk("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter and long-latency scoreboard sitting directly upstream of the core's register file write port. It merges single-cycle ALU results with results from long-latency units (load, mul/div, FPU) into the file's single write port. It tracks which registers still await a long-latency result so that issue logic can detect RAW/WAW hazards. Output write signals are registered and drive the register file's `we`/`wa`/`wd` directly.

## Interface
Parameters:
- `DEPTH`, 2: long-path FIFO entries (power of two, ≥2)
- `STARVE`, 3: cycles the FIFO head may wait before `stall_req` asserts

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `alu_valid`  in  1  ALU result present; always accepted, no ready
- `alu_rd`  in  5  ALU destination
- `alu_data`  in  32  ALU result
- `lng_valid`  in  1  long-latency result offered
- `lng_ready`  out  1  long-path FIFO not full
- `lng_rd`  in  5  long-latency destination
- `lng_data`  in  32  long-latency result
- `iss_valid`  in  1  long-latency op issued this cycle
- `iss_rd`  in  5  its destination; sets busy bit
- `q_rs1`, `q_rs2`  in  5  hazard query addresses
- `busy1`, `busy2`  out  1  combinational busy bit of `q_rs1`/`q_rs2`
- `stall_req`  out  1  request to front-end for one ALU bubble
- `rf_we`  out  1  register file write enable (registered)
- `rf_wa`  out  5  register file write address (registered)
- `rf_wd`  out  32  register file write data (registered)

## Operation
- Long path: `lng_valid && lng_ready` pushes {rd, data} into FIFO; `lng_ready = !full` (registered count, no same-cycle pop credit).
- Arbitration each cycle, fixed priority: `alu_valid` wins; else FIFO head pops. At most one selection per cycle.
- Selected entry registered onto `rf_*` next edge; no selection → `rf_we=0`, `rf_wa`/`rf_wd` hold previous values.
- x0 rule: selection with rd=0 is consumed (pops FIFO if long) but `rf_we` stays 0; `iss_rd=0` never sets busy; `busy1/2` for address 0 always 0.
- Scoreboard: 32-bit `busy` register. `iss_valid` sets `busy[iss_rd]`. Busy clears on the edge ending a cycle in which `rf_we=1` for a long-path entry of that address (RAM written same edge). ALU writes never clear busy.
- Same edge set and clear of same address: set wins.
- Starvation: counter increments each cycle the FIFO is non-empty and the head loses to ALU; resets on pop or empty. `stall_req` = counter ≥ `STARVE`, registered. Front-end guarantees `alu_valid=0` the cycle after seeing `stall_req`.
- WAW between ALU and an outstanding long op is prevented by issue logic via `busy`; not checked here.

## Timing
- Reset (`rstn` low, async): FIFO empty, `lng_ready=1`, `busy=0`, counter 0, `stall_req=0`, `rf_we=0`, `rf_wa=0`, `rf_wd=0`. Reset mid-operation discards all queued entries.
- ALU result cycle N → `rf_we=1` in N+1 → register file updated at end of N+1.
- Long push cycle N, no ALU contention → pop N+1, `rf_we` N+2, busy low from N+3.
- FIFO full: `lng_ready=0` the cycle after the filling push; push+pop same cycle when full is impossible (ready low).
- Push and pop same cycle when non-empty: count unchanged, order preserved (FIFO).
- Pointers wrap modulo `DEPTH`.

## Test plan
- Reset: hold `rstn=0` mid-stream with 2 entries queued → all outputs at reset values, `lng_ready=1`, busy all 0 after release.
- ALU only: `alu_valid=1, rd=5, data=0x12345678` at N → `rf_we=1, rf_wa=5, rf_wd=0x12345678` at N+1; rd=0 → `rf_we=0`.
- Long path + scoreboard: issue rd=7, later push {7, 0xDEADBEEF} → `busy1`(q_rs1=7)=1 until write, `rf_we` 2 cycles after push, busy low the following cycle.
- Contention/backpressure: `alu_valid` held 1, push 2 long entries → `lng_ready=0` after second push, `stall_req=1` after 3 lost cycles; on ALU bubble entries drain in push order.
- Simultaneous set/clear: long writeback of rd=9 clearing same edge as new `iss_rd=9` → `busy[9]` stays 1.
- Wrap: 10 back-to-back long pushes with no ALU traffic → 10 writes, in order, data intact, `lng_ready` never drops.
